niox_dmem_ctrl: RTL and testbench

- Load/store bus master sitting directly upstream of the NIOX data RAM; converts CPU load/store requests (byte/half/word, signed/unsigned) into the RAM's single-cycle strobe/ack bus cycle.
- Generates byte enables, replicates store data across lanes, and extracts and extends load data.
- Detects misaligned accesses and bus timeouts, and reports them to the CPU as errors.

---
 rtl/niox_dmem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_niox_dmem_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/niox_dmem_ctrl.sv
// niox_dmem_ctrl: load/store bus master between the NIOX CPU and its data RAM.
// Latency: strobes one cycle after req, done_o two cycles after that with a 1-cycle-ack RAM.
// Backpressure: req_i is only looked at in IDLE; busy_o is high while a request is in flight.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_i, wr_i, size_i, sgn_i,
//   addr_i, wdata_i              CPU request (latched when accepted in IDLE)
//   busy_o, done_o, err_o,
//   rdata_o                      CPU status / load result
//   mem_addr_o, mem_data_o,
//   mem_be_o, mem_we_o,
//   mem_sel_o                    registered RAM bus outputs
//   mem_data_i, mem_ack_i        RAM read data and acknowledge
module niox_dmem_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        wr_i,
   input  logic [1:0]  size_i,
   input  logic        sgn_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic [3:0]  mem_be_o,
   output logic        mem_we_o,
   output logic        mem_sel_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Counter value at which the current no-ack cycle is the last one allowed.
   localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

   state_t      state;
   logic [3:0]  to_cnt;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        sgn_q;
   logic        wr_q;

   logic        aligned;
   logic [3:0]  be_c;
   logic [31:0] wdat_c;
   logic [31:0] shifted;
   logic [31:0] ld_val;

   assign busy_o = (state != S_IDLE);

   // Request decode from the live CPU inputs; only used in the IDLE accept cycle.
   always_comb begin
      aligned = 1'b0;
      be_c    = 4'b0000;
      wdat_c  = wdata_i;
      case (size_i)
         2'b00: begin
            aligned = 1'b1;
            be_c    = 4'b0001 << addr_i[1:0];
            wdat_c  = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            aligned = ~addr_i[0];
            be_c    = 4'b0011 << addr_i[1:0];
            wdat_c  = {2{wdata_i[15:0]}};
         end
         2'b10: begin
            aligned = (addr_i[1:0] == 2'b00);
            be_c    = 4'b1111;
            wdat_c  = wdata_i;
         end
         default: begin
            aligned = 1'b0;
            be_c    = 4'b0000;
            wdat_c  = wdata_i;
         end
      endcase
   end

   // Load path: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      shifted = mem_data_i >> {lane_q, 3'b000};
      ld_val  = shifted;
      case (size_q)
         2'b00:   ld_val = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
         2'b01:   ld_val = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
         default: ld_val = shifted;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         to_cnt     <= 4'd0;
         lane_q     <= 2'b00;
         size_q     <= 2'b00;
         sgn_q      <= 1'b0;
         wr_q       <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         rdata_o    <= 32'd0;
         mem_addr_o <= 32'd0;
         mem_data_o <= 32'd0;
         mem_be_o   <= 4'b0000;
         mem_we_o   <= 1'b0;
         mem_sel_o  <= 1'b0;
      end else begin
         // Status pulses last exactly one cycle.
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_i) begin
                  if (aligned) begin
                     lane_q     <= addr_i[1:0];
                     size_q     <= size_i;
                     sgn_q      <= sgn_i;
                     wr_q       <= wr_i;
                     to_cnt     <= 4'd0;
                     mem_addr_o <= {addr_i[31:2], 2'b00};
                     mem_data_o <= wdat_c;
                     mem_be_o   <= be_c;
                     mem_we_o   <= wr_i;
                     mem_sel_o  <= ~wr_i;
                     state      <= S_REQ;
                  end else begin
                     // Misaligned or reserved size: report without touching the bus.
                     done_o <= 1'b1;
                     err_o  <= 1'b1;
                     state  <= S_DONE;
                  end
               end
            end
            S_REQ: begin
               if (mem_ack_i) begin
                  // Drop strobes on the ack edge so the RAM does not re-ack.
                  mem_we_o  <= 1'b0;
                  mem_sel_o <= 1'b0;
                  mem_be_o  <= 4'b0000;
                  done_o    <= 1'b1;
                  if (!wr_q) begin
                     rdata_o <= ld_val;
                  end
                  state <= S_DONE;
               end else if (to_cnt == TO_LAST) begin
                  mem_we_o  <= 1'b0;
                  mem_sel_o <= 1'b0;
                  mem_be_o  <= 4'b0000;
                  done_o    <= 1'b1;
                  err_o     <= 1'b1;
                  to_cnt    <= to_cnt + 4'd1;
                  state     <= S_DONE;
               end else begin
                  to_cnt <= to_cnt + 4'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_niox_dmem_ctrl.sv
// Bench for niox_dmem_ctrl: table of load/store vectors against a small RAM model,
// with expected completions queued at issue and popped at done_o, plus
// hand-written timeout and mid-request reset sequences.
module tb_niox_dmem_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_i = 1'b0;
   logic        wr_i = 1'b0;
   logic [1:0]  size_i = 2'b00;
   logic        sgn_i = 1'b0;
   logic [31:0] addr_i = 32'd0;
   logic [31:0] wdata_i = 32'd0;
   logic        busy_o, done_o, err_o;
   logic [31:0] rdata_o, mem_addr_o, mem_data_o;
   logic [3:0]  mem_be_o;
   logic        mem_we_o, mem_sel_o;
   logic [31:0] mem_data_i;
   logic        mem_ack_i;

   niox_dmem_ctrl #(.TIMEOUT(15)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .wr_i(wr_i), .size_i(size_i),
      .sgn_i(sgn_i), .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o),
      .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_be_o(mem_be_o), .mem_we_o(mem_we_o),
      .mem_sel_o(mem_sel_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   // RAM model: acks one cycle after a strobe, toggling if the strobe is held.
   logic [31:0] ram [0:255];
   logic        ack_en = 1'b1;
   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'd0;
      mem_ack_i  = 1'b0;
      mem_data_i = 32'd0;
   end
   always @(posedge clk_i) begin
      mem_ack_i <= ack_en & (mem_we_o | mem_sel_o) & ~mem_ack_i;
      if (mem_sel_o && !mem_ack_i) mem_data_i <= ram[mem_addr_o[9:2]];
      if (mem_we_o && !mem_ack_i) begin
         for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) ram[mem_addr_o[9:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
      end
   end

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [3:0]  be;
      logic [31:0] mdata;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      int   lat;
      @(negedge clk_i);
      req_i = 1'b1; wr_i = v.wr; size_i = v.size; sgn_i = v.sgn;
      addr_i = v.addr; wdata_i = v.wdata;
      e.err = v.err; e.rdata = v.rdata;
      sb.push_back(e);
      @(posedge clk_i); #1;
      // Scramble the inputs: the request must already be latched.
      req_i = 1'b0; wr_i = ~v.wr; sgn_i = ~v.sgn; addr_i = ~v.addr; wdata_i = ~v.wdata;
      if (!v.err) begin
         chk("sel", {31'd0, mem_sel_o}, {31'd0, ~v.wr});
         chk("we", {31'd0, mem_we_o}, {31'd0, v.wr});
         chk("be", {28'd0, mem_be_o}, {28'd0, v.be});
         chk("maddr", mem_addr_o, {v.addr[31:2], 2'b00});
         if (v.wr) chk("mdata", mem_data_o, v.mdata);
      end else begin
         chk("no_strobe", {30'd0, mem_sel_o, mem_we_o}, 32'd0);
      end
      lat = 0;
      while (!done_o && lat < 40) begin
         @(posedge clk_i); #1;
         lat++;
      end
      if (!done_o) begin
         n_vec++; n_bad++;
         $display("FAIL done_timeout: no done_o within 40 cycles at %0t", $time);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         chk("latency", lat, v.err ? 32'd0 : 32'd2);
         chk("err", {31'd0, err_o}, {31'd0, e.err});
         chk("rdata", rdata_o, e.rdata);
         chk("strobes_off", {28'd0, mem_be_o} | {30'd0, mem_sel_o, mem_we_o}, 32'd0);
      end
      @(posedge clk_i); #1;
      chk("idle", {30'd0, busy_o, done_o}, 32'd0);
   endtask

   vec_t tbl[16];
   vec_t v;
   int   hi_cnt;
   int   done_cnt;

   initial begin
      // wr, size, sgn, addr, wdata, err, be, mdata, rdata
      tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h00000000};
      tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        1'b0, 4'b1111, 32'h0,        32'hDEADBEEF};
      tbl[2]  = '{1'b1, 2'b00, 1'b0, 32'h103, 32'h12345680, 1'b0, 4'b1000, 32'h80808080, 32'hDEADBEEF};
      tbl[3]  = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
      tbl[4]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        1'b0, 4'b1000, 32'h0,        32'h00000080};
      tbl[5]  = '{1'b1, 2'b01, 1'b0, 32'h202, 32'hABCD8001, 1'b0, 4'b1100, 32'h80018001, 32'h00000080};
      tbl[6]  = '{1'b0, 2'b01, 1'b1, 32'h202, 32'h0,        1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
      tbl[7]  = '{1'b0, 2'b01, 1'b0, 32'h202, 32'h0,        1'b0, 4'b1100, 32'h0,        32'h00008001};
      tbl[8]  = '{1'b0, 2'b00, 1'b0, 32'h100, 32'h0,        1'b0, 4'b0001, 32'h0,        32'h000000EF};
      tbl[9]  = '{1'b0, 2'b00, 1'b1, 32'h101, 32'h0,        1'b0, 4'b0010, 32'h0,        32'hFFFFFFBE};
      tbl[10] = '{1'b0, 2'b01, 1'b1, 32'h100, 32'h0,        1'b0, 4'b0011, 32'h0,        32'hFFFFBEEF};
      tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h101, 32'h0,        1'b1, 4'b0000, 32'h0,        32'hFFFFBEEF};
      tbl[12] = '{1'b1, 2'b01, 1'b0, 32'h201, 32'h1234,     1'b1, 4'b0000, 32'h0,        32'hFFFFBEEF};
      tbl[13] = '{1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        1'b1, 4'b0000, 32'h0,        32'hFFFFBEEF};
      tbl[14] = '{1'b1, 2'b00, 1'b0, 32'h201, 32'h0000005A, 1'b0, 4'b0010, 32'h5A5A5A5A, 32'hFFFFBEEF};
      tbl[15] = '{1'b0, 2'b10, 1'b0, 32'h200, 32'h0,        1'b0, 4'b1111, 32'h0,        32'h80015A00};

      // Reset state
      @(posedge clk_i); @(posedge clk_i); #1;
      chk("rst_status", {29'd0, busy_o, done_o, err_o}, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_bus", {26'd0, mem_be_o, mem_we_o, mem_sel_o} | mem_addr_o | mem_data_o, 32'd0);
      @(negedge clk_i); rst_i = 1'b0;

      for (int i = 0; i < 16; i++) run_vec(tbl[i]);

      // Timeout: RAM never acks; the read strobe must stay up for 15 cycles.
      ack_en = 1'b0;
      @(negedge clk_i);
      req_i = 1'b1; wr_i = 1'b0; size_i = 2'b10; sgn_i = 1'b0; addr_i = 32'h100;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      hi_cnt = 0;
      for (int c = 0; c < 40 && !done_o; c++) begin
         if (mem_sel_o) hi_cnt++;
         @(posedge clk_i); #1;
      end
      chk("to_sel_cycles", hi_cnt, 32'd15);
      chk("to_done_err", {30'd0, done_o, err_o}, 32'd3);
      chk("to_sel_drop", {31'd0, mem_sel_o}, 32'd0);
      chk("to_rdata", rdata_o, 32'h80015A00);
      @(posedge clk_i); #1;
      chk("to_idle", {31'd0, busy_o}, 32'd0);
      ack_en = 1'b1;

      // Asynchronous reset while a store strobe is up.
      @(negedge clk_i);
      req_i = 1'b1; wr_i = 1'b1; size_i = 2'b10; addr_i = 32'h300; wdata_i = 32'h11223344;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      chk("rr_we_up", {31'd0, mem_we_o}, 32'd1);
      #2 rst_i = 1'b1;
      #1;
      chk("rr_status", {29'd0, busy_o, done_o, err_o}, 32'd0);
      chk("rr_bus", {26'd0, mem_be_o, mem_we_o, mem_sel_o} | mem_addr_o | mem_data_o, 32'd0);
      chk("rr_rdata", rdata_o, 32'd0);
      @(negedge clk_i); @(negedge clk_i); rst_i = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk_i); #1;
         if (done_o) done_cnt++;
      end
      chk("rr_no_done", done_cnt, 32'd0);

      // Recovery after reset.
      v = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h80ADBEEF};
      run_vec(v);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
